// File: rtl/ttpu_pkg.sv
// Types and constants shared by the TTPU vector stages (vector_adder, vector_activation).
package ttpu_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RELU6 = 2'b11
  } act_func_e;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_NEG_ZERO = 16'h8000;
  localparam fp16_t FP16_SIX      = 16'h4600;

endpackage

// File: rtl/vector_activation_if.sv
// Start/ready handshake and vector buses between a driver and vector_activation.
interface vector_activation_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 64
);
  import ttpu_pkg::*;

  logic                                  start;
  act_func_e                             func;
  logic [NUM_UNITS-1:0]                  active_units;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  In_x;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  Out;
  logic                                  ready;
  logic                                  busy;

  modport master (
    output start, func, active_units, In_x,
    input  Out, ready, busy
  );

  modport slave (
    input  start, func, active_units, In_x,
    output Out, ready, busy
  );

endinterface

// File: rtl/fp16_activation.sv
// Combinational FP16 activation for one element: pass, ReLU, leaky ReLU (2^-LEAK_SHIFT), ReLU6.
module fp16_activation
  import ttpu_pkg::*;
#(
  parameter int LEAK_SHIFT = 3
) (
  input  fp16_t     x,
  input  act_func_e func,
  output fp16_t     y
);

  localparam logic [4:0] LS = 5'(LEAK_SHIFT);

  // Scaling by 2^-LS is an exponent decrement; results that would go subnormal flush to -0.
  function automatic fp16_t leaky_scale(input fp16_t v);
    logic [4:0] e;
    e = v[14:10];
    if (!v[15] || e == 5'h1F) return v;
    if (e > LS) return {1'b1, e - LS, v[9:0]};
    return FP16_NEG_ZERO;
  endfunction

  // Positive magnitudes compare as unsigned integers; NaN is exempt from the clamp.
  function automatic fp16_t relu6_clamp(input fp16_t v);
    if (v[15]) return FP16_POS_ZERO;
    if (v[14:10] == 5'h1F && v[9:0] != 10'd0) return v;
    if (v[14:0] > FP16_SIX[14:0]) return FP16_SIX;
    return v;
  endfunction

  always_comb begin
    y = x;
    case (func)
      ACT_PASS:  y = x;
      ACT_RELU:  y = x[15] ? FP16_POS_ZERO : x;
      ACT_LEAKY: y = leaky_scale(x);
      ACT_RELU6: y = relu6_clamp(x);
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/vector_activation.sv
// Element-wise activation over a captured FP16 vector, LANES elements per cycle, start/ready handshake.
module vector_activation
  import ttpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 64,
  parameter int LANES      = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic               clk,
  input  logic               reset,
  vector_activation_if.slave bus
);

  localparam int NUM_GROUPS = NUM_UNITS / LANES;
  localparam int G_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int IDX_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [G_W-1:0] LAST_G = G_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                               state_q, state_d;
  logic [G_W-1:0]                       g_q, g_d;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] x_q, x_d;
  logic [NUM_UNITS-1:0]                 act_q, act_d;
  act_func_e                            func_q, func_d;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_q, out_d;

  logic [IDX_W-1:0] base;
  fp16_t            lane_f [LANES];
  fp16_t            lane_y [LANES];

  assign base = IDX_W'(g_q) * IDX_W'(LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] idx;
    assign idx = base + IDX_W'(l);

    fp16_activation #(.LEAK_SHIFT(LEAK_SHIFT)) u_act (
      .x    (x_q[idx]),
      .func (func_q),
      .y    (lane_f[l])
    );

    assign lane_y[l] = act_q[idx] ? lane_f[l] : FP16_POS_ZERO;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    x_d     = x_q;
    act_d   = act_q;
    func_d  = func_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          g_d     = '0;
          x_d     = bus.In_x;
          act_d   = bus.active_units;
          func_d  = bus.func;
        end
      end
      S_RUN: begin
        // Only the current group is overwritten; the rest of Out keeps stale data.
        for (int l = 0; l < LANES; l++) begin
          out_d[base + IDX_W'(l)] = lane_y[l];
        end
        g_d = g_q + G_W'(1);
        if (g_q == LAST_G) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      x_q     <= '0;
      act_q   <= '0;
      func_q  <= ACT_PASS;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      x_q     <= x_d;
      act_q   <= act_d;
      func_q  <= func_d;
      out_q   <= out_d;
    end
  end

  assign bus.Out   = out_q;
  assign bus.ready = (state_q == S_DONE);
  assign bus.busy  = (state_q == S_RUN);

endmodule

// File: tb/tb_vector_activation.sv
// Randomized bench for vector_activation with a timeline-based reference model and per-cycle compare.
module tb_vector_activation;
  import ttpu_pkg::*;

  localparam int DW = 16;
  localparam int NU = 64;
  localparam int LN = 8;
  localparam int LS = 3;
  localparam int NG = NU / LN;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vector_activation_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU)) bus ();

  vector_activation #(
    .DATA_WIDTH(DW), .NUM_UNITS(NU), .LANES(LN), .LEAK_SHIFT(LS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, got, exp);
    end
  endtask

  // Reference activation written from the value rules.
  function automatic fp16_t ref_act(input fp16_t x, input act_func_e f);
    bit     neg;
    int     ex;
    bit     nan;
    neg = x[15];
    ex  = int'(x[14:10]);
    nan = (ex == 31) && (x[9:0] != 0);
    case (f)
      ACT_PASS:  return x;
      ACT_RELU:  return neg ? 16'h0000 : x;
      ACT_LEAKY: begin
        if (!neg || ex == 31) return x;
        if (ex > LS) return x - fp16_t'(LS << 10);
        return 16'h8000;
      end
      default: begin
        if (neg) return 16'h0000;
        if (nan) return x;
        if ({1'b0, x[14:0]} > 16'h4600) return 16'h4600;
        return x;
      end
    endcase
  endfunction

  // Model: remembers when the last accepted start happened and what was captured.
  int        cyc    = 0;
  int        t0     = 0;
  bit        m_seen = 1'b0;
  fp16_t     cap_x [NU];
  bit        cap_a [NU];
  act_func_e cap_f  = ACT_PASS;
  fp16_t     prev  [NU];

  function automatic bit m_busy();
    return m_seen && (cyc - t0) < NG;
  endfunction

  function automatic fp16_t m_out(input int i);
    if (!m_seen) return prev[i];
    if ((cyc - t0) >= (i / LN) + 1) return cap_a[i] ? ref_act(cap_x[i], cap_f) : 16'h0000;
    return prev[i];
  endfunction

  initial begin
    for (int i = 0; i < NU; i++) begin
      prev[i] = 16'h0000; cap_x[i] = 16'h0000; cap_a[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_seen = 1'b0;
        for (int i = 0; i < NU; i++) prev[i] = 16'h0000;
      end else if (bus.start && !m_busy()) begin
        for (int i = 0; i < NU; i++) begin
          prev[i]  = m_out(i);
          cap_x[i] = bus.In_x[i];
          cap_a[i] = bus.active_units[i];
        end
        cap_f  = bus.func;
        cyc    = cyc + 1;
        t0     = cyc;
        m_seen = 1'b1;
      end else begin
        cyc = cyc + 1;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NU; i++) chk("out", i, bus.Out[i], m_out(i));
      chk("ready", -1, 16'(bus.ready), 16'(m_seen && !m_busy()));
      chk("busy",  -1, 16'(bus.busy),  16'(m_busy()));
    end
  end

  logic [NU-1:0][DW-1:0] stim_x;
  logic [NU-1:0]         stim_a;
  act_func_e             stim_f;

  function automatic fp16_t rnd_fp();
    fp16_t sp [9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                      16'hFE00, 16'h4600, 16'h4601, 16'hC600};
    case ($urandom_range(0, 5))
      0:       return sp[$urandom_range(0, 8)];
      1:       return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), 10'($urandom)};
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic rnd_stim(input bit all_active);
    for (int i = 0; i < NU; i++) stim_x[i] = rnd_fp();
    stim_a = all_active ? {NU{1'b1}} : {32'($urandom), 32'($urandom)};
    stim_f = act_func_e'(2'($urandom_range(0, 3)));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.In_x         = stim_x;
    bus.active_units = stim_a;
    bus.func         = stim_f;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  // Called at the negedge right after the start edge; returns edges-to-ready and busy cycles.
  task automatic run_wait(input int poke_at, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ready) begin lat = c; break; end
      if (bus.busy) bc++;
      if (c == poke_at) begin
        for (int i = 0; i < NU; i++) bus.In_x[i] = rnd_fp();
        bus.active_units = {32'($urandom), 32'($urandom)};
        bus.func         = act_func_e'(2'($urandom_range(0, 3)));
        bus.start        = 1'b1;
      end
      if (c == poke_at + 1) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("wait_ready", -1, 16'(bus.ready), 16'd1);
  endtask

  int lat, bc;

  initial begin
    bus.start        = 1'b0;
    bus.func         = ACT_PASS;
    bus.active_units = '0;
    bus.In_x         = '0;

    chk("pin_leaky_m2",   -1, ref_act(16'hC000, ACT_LEAKY), 16'hB400);
    chk("pin_leaky_e3",   -1, ref_act(16'h8C00, ACT_LEAKY), 16'h8000);
    chk("pin_leaky_ninf", -1, ref_act(16'hFC00, ACT_LEAKY), 16'hFC00);
    chk("pin_leaky_pos",  -1, ref_act(16'h4000, ACT_LEAKY), 16'h4000);
    chk("pin_relu6_7",    -1, ref_act(16'h4700, ACT_RELU6), 16'h4600);
    chk("pin_relu6_5",    -1, ref_act(16'h4500, ACT_RELU6), 16'h4500);
    chk("pin_relu6_inf",  -1, ref_act(16'h7C00, ACT_RELU6), 16'h4600);
    chk("pin_relu6_nz",   -1, ref_act(16'h8000, ACT_RELU6), 16'h0000);
    chk("pin_relu6_nan",  -1, ref_act(16'h7E00, ACT_RELU6), 16'h7E00);
    chk("pin_relu_ninf",  -1, ref_act(16'hFC00, ACT_RELU),  16'h0000);

    repeat (3) @(negedge clk);
    chk("rst_out0",  -1, bus.Out[0], 16'h0000);
    chk("rst_ready", -1, 16'(bus.ready), 16'd0);
    chk("rst_busy",  -1, 16'(bus.busy), 16'd0);
    reset = 1'b1;

    // ReLU on alternating +1/-1
    for (int i = 0; i < NU; i++) stim_x[i] = (i % 2 == 0) ? 16'h3C00 : 16'hBC00;
    stim_a = {NU{1'b1}};
    stim_f = ACT_RELU;
    pulse_start();
    run_wait(-1, lat, bc);
    chk("relu_latency", -1, 16'(lat), 16'd8);
    chk("relu_busy",    -1, 16'(bc),  16'd8);
    chk("relu_out0",  0, bus.Out[0],  16'h3C00);
    chk("relu_out1",  1, bus.Out[1],  16'h0000);
    chk("relu_out62", 62, bus.Out[62], 16'h3C00);
    chk("relu_out63", 63, bus.Out[63], 16'h0000);

    // Leaky ReLU corner values
    rnd_stim(1'b1);
    stim_x[0] = 16'hC000; stim_x[1] = 16'h8C00; stim_x[2] = 16'hFC00; stim_x[3] = 16'h4000;
    stim_f = ACT_LEAKY;
    pulse_start();
    run_wait(-1, lat, bc);
    chk("leaky_m2",   0, bus.Out[0], 16'hB400);
    chk("leaky_e3",   1, bus.Out[1], 16'h8000);
    chk("leaky_ninf", 2, bus.Out[2], 16'hFC00);
    chk("leaky_pos",  3, bus.Out[3], 16'h4000);

    // ReLU6 corner values
    rnd_stim(1'b1);
    stim_x[0] = 16'h4700; stim_x[1] = 16'h4500; stim_x[2] = 16'h7C00;
    stim_x[3] = 16'h8000; stim_x[4] = 16'h7E00;
    stim_f = ACT_RELU6;
    pulse_start();
    run_wait(-1, lat, bc);
    chk("relu6_7",   0, bus.Out[0], 16'h4600);
    chk("relu6_5",   1, bus.Out[1], 16'h4500);
    chk("relu6_inf", 2, bus.Out[2], 16'h4600);
    chk("relu6_nz",  3, bus.Out[3], 16'h0000);
    chk("relu6_nan", 4, bus.Out[4], 16'h7E00);

    // Element enables
    for (int i = 0; i < NU; i++) stim_x[i] = 16'h4200;
    stim_a = 64'h000F;
    stim_f = ACT_PASS;
    pulse_start();
    run_wait(-1, lat, bc);
    chk("en_out3",  3,  bus.Out[3],  16'h4200);
    chk("en_out4",  4,  bus.Out[4],  16'h0000);
    chk("en_out63", 63, bus.Out[63], 16'h0000);

    // start and input changes during RUN are ignored
    rnd_stim(1'b1);
    stim_f = ACT_RELU;
    pulse_start();
    run_wait(3, lat, bc);
    chk("ign_busy",    -1, 16'(bc), 16'd8);
    chk("ign_latency", -1, 16'(lat), 16'd8);
    chk("ign_out5",     5, bus.Out[5], ref_act(stim_x[5], ACT_RELU));

    // Asynchronous reset in the middle of RUN
    rnd_stim(1'b1);
    pulse_start();
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_out0",  0, bus.Out[0], 16'h0000);
    chk("abort_ready", -1, 16'(bus.ready), 16'd0);
    chk("abort_busy",  -1, 16'(bus.busy), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rnd_stim(1'b0);
    pulse_start();
    run_wait(-1, lat, bc);
    chk("post_abort_latency", -1, 16'(lat), 16'd8);

    // Randomized runs, back-to-back restarts and mid-run pokes
    for (int r = 0; r < 25; r++) begin
      rnd_stim($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      pulse_start();
      run_wait(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1, lat, bc);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
